perf_monitor: RTL and testbench
===============================

# perf_monitor

Hardware performance monitor that sits beside the single-cycle CPU core and measures its run from hardware: it counts clock cycles, retired instructions and (optionally) stall cycles from a start pulse until the program counter reaches a stop address. Results are read over a small registered request/acknowledge port, so CPI can be computed by software or a bench without probing core internals. It is the in-design counterpart of the bench-side cycle counting used for single-cycle CPU runs.

## Interface
- PC_W, 32, program counter width
- CNT_W, 32, width of each event counter
- STOP_PC, 400, PC value at or above which measurement ends (400 = 100 instructions at 4 bytes each)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  single-cycle pulse that clears the counters and begins measurement
- pc_in  input  PC_W  current PC of the core
- retire  input  1  one instruction retired this cycle
- stall  input  1  core stalled this cycle
- done  output  1  measurement finished (state DONE)
- running  output  1  measurement in progress (state RUN)
- rd_req  input  1  read request, sampled on rising edge
- rd_sel  input  2  0 = cycles, 1 = retired instructions, 2 = stall cycles, 3 = status word
- rd_ack  output  1  read data valid, exactly one cycle after the accepted rd_req
- rd_data  output  CNT_W  read result

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: counters hold; start -> clear all counters, go to RUN.
- RUN, each cycle: cycle_cnt += 1; retire -> instr_cnt += 1; stall -> stall_cnt += 1. If pc_in >= STOP_PC (unsigned) -> DONE; that cycle's events are still counted.
- DONE: counters frozen; done = 1; start -> clear counters, back to RUN.
- start in RUN: restart, meaning the counters are cleared and the block stays in RUN. The cycle carrying start counts as cycle 0; nothing is counted in it.
- start together with pc_in >= STOP_PC: start wins.
- Counters saturate at 2^CNT_W-1 and never wrap. Any counter saturating sets the sticky ovf flag, which is cleared by start or reset.
- Status word (rd_sel = 3): bit0 = running, bit1 = done, bit2 = ovf, all other bits 0.
- The read port is pipelined. A new rd_req is accepted every cycle. rd_data reflects counter values as of the edge at which rd_req was sampled, before that edge's increment.
- With rd_req low, rd_ack = 0 and rd_data holds its last value.

## Timing
- Reset values: done = 0, running = 0, rd_ack = 0, rd_data = 0; all counters 0; ovf = 0; state IDLE.
- start sampled at edge N -> running = 1 after edge N. The first counted cycle is edge N+1.
- pc_in >= STOP_PC sampled at edge M -> done = 1 and running = 0 after edge M.
- Read latency: 1 cycle. rd_req at edge K -> rd_ack = 1 and rd_data valid after edge K, for one cycle.
- Reset asserted mid-run or mid-read: all state cleared immediately and any pending rd_ack is dropped.

## Configuration
- PERF_STALL_CNT_EN defined: the stall counter is implemented, and rd_sel = 2 returns it.
- PERF_STALL_CNT_EN undefined: no stall counter register exists, the stall input is ignored, rd_sel = 2 returns 0, and stall activity cannot set ovf.

## Test plan
- Basic run: reset, then start; retire every cycle; pc_in steps by 4 per cycle from 0. When pc_in reaches 400 -> done = 1. Reads return cycles = 101 and instructions = 101, with status = 0b010.
- Stall accounting (macro defined): stall asserted for 10 of 50 run cycles, with retire low on those cycles -> stalls = 10 and instructions = 40. With the macro undefined -> rd_sel = 2 returns 0.
- Restart: start pulsed in DONE, and again mid-RUN after 20 cycles -> counters restart from 0 each time. start in the same cycle as pc_in = 400 -> block stays in RUN.
- Saturation: with CNT_W = 4, run 20 cycles -> cycles reads 15 and the status word's ovf bit is 1. The next start clears ovf to 0.
- Read pipeline: rd_req held high for 4 consecutive cycles with rd_sel = 0,1,2,3 during RUN -> 4 consecutive rd_ack pulses, each carrying the pre-increment value from its own request edge.
- Async reset: assert reset mid-RUN between clock edges, while a read is outstanding -> done, running, rd_ack and rd_data are 0 immediately. After release, reading cycles returns 0.

Source files
------------

// File: rtl/perf_monitor.sv
// Cycle/retire/stall performance monitor for the single-cycle core, read via a one-cycle-latency request port.
// Optional stall counter is enabled by defining PERF_STALL_CNT_EN.
module perf_monitor #(
    parameter int          PC_W    = 32,
    parameter int          CNT_W   = 32,
    parameter int unsigned STOP_PC = 400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             retire,
    input  logic             stall,
    output logic             done,
    output logic             running,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data
);

    localparam logic [PC_W-1:0]  STOP_PC_V = PC_W'(STOP_PC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_ovf;
    logic             r_rd_ack;
    logic [CNT_W-1:0] r_rd_data;

    logic             w_count;
    logic [CNT_W-1:0] w_cycle_nxt;
    logic [CNT_W-1:0] w_instr_nxt;
    logic             w_cycle_hit;
    logic             w_instr_hit;
    logic [CNT_W-1:0] w_stall_val;
    logic             w_stall_hit;
    logic [CNT_W-1:0] w_status;
    logic [CNT_W-1:0] w_rd_mux;

    // Returns {saturation_hit, next_value}; a hit means an increment was refused at full scale.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        logic [CNT_W:0] res;
        if (en && (cnt == CNT_MAX))
            res = {1'b1, cnt};
        else
            res = {1'b0, cnt + CNT_W'(en)};
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                if (start)
                    w_next = S_RUN;
                else if (pc_in >= STOP_PC_V)
                    w_next = S_DONE;
            end
            S_DONE: if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    assign running = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    // The cycle carrying start is cycle 0 of the new run and is never counted.
    assign w_count = running && !start;

    assign {w_cycle_hit, w_cycle_nxt} = sat_inc(r_cycle_cnt, 1'b1);
    assign {w_instr_hit, w_instr_nxt} = sat_inc(r_instr_cnt, retire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_ovf       <= 1'b0;
        end else if (start) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_ovf       <= 1'b0;
        end else if (w_count) begin
            r_cycle_cnt <= w_cycle_nxt;
            r_instr_cnt <= w_instr_nxt;
            r_ovf       <= r_ovf | w_cycle_hit | w_instr_hit | w_stall_hit;
        end
    end

`ifdef PERF_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_nxt;

    assign {w_stall_hit, w_stall_nxt} = sat_inc(r_stall_cnt, stall);
    assign w_stall_val = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (start)
            r_stall_cnt <= '0;
        else if (w_count)
            r_stall_cnt <= w_stall_nxt;
    end
`else
    logic w_unused_stall;

    assign w_unused_stall = stall;
    assign w_stall_hit    = 1'b0;
    assign w_stall_val    = '0;
`endif

    always_comb begin
        w_status    = '0;
        w_status[0] = running;
        w_status[1] = done;
        w_status[2] = r_ovf;
    end

    always_comb begin
        w_rd_mux = '0;
        case (rd_sel)
            2'd0: w_rd_mux = r_cycle_cnt;
            2'd1: w_rd_mux = r_instr_cnt;
            2'd2: w_rd_mux = w_stall_val;
            2'd3: w_rd_mux = w_status;
            default: w_rd_mux = '0;
        endcase
    end

    // Read capture uses the pre-increment register values at the request edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= rd_req;
            if (rd_req)
                r_rd_data <= w_rd_mux;
        end
    end

    assign rd_ack  = r_rd_ack;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit instance plus a 4-bit-counter instance sharing stimulus.
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc_in;
    logic        retire;
    logic        stall;
    logic        rd_req;
    logic [1:0]  rd_sel;

    logic        done, running, rd_ack;
    logic [31:0] rd_data;
    logic        done_s, running_s, rd_ack_s;
    logic [3:0]  rd_data_s;

    int n_vec = 0;
    int n_err = 0;

`ifdef PERF_STALL_CNT_EN
    localparam logic [31:0] EXP_STALLS = 32'd10;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

    perf_monitor #(.PC_W(32), .CNT_W(32), .STOP_PC(400)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
        .retire(retire), .stall(stall), .done(done), .running(running),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data)
    );

    perf_monitor #(.PC_W(32), .CNT_W(4), .STOP_PC(400)) dut_s (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
        .retire(retire), .stall(stall), .done(done_s), .running(running_s),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack_s), .rd_data(rd_data_s)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel);
        rd_req = 1'b1;
        rd_sel = sel;
        step();
        rd_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pc_in = '0; retire = 1'b0; stall = 1'b0;
        rd_req = 1'b0; rd_sel = 2'd0;
        step(); step();
        check("rst_done", 32'(done), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_ack", 32'(rd_ack), 32'd0);
        check("rst_data", rd_data, 32'd0);
        reset = 1'b0;
        step();
        rd(2'd0);
        check("rst_cycles", rd_data, 32'd0);

        // Basic run: pc 0,4,...,400 with retire every cycle.
        pulse_start();
        check("basic_running", 32'(running), 32'd1);
        for (int i = 0; i <= 100; i++) begin
            pc_in = 32'(4 * i);
            retire = 1'b1;
            step();
            if (i == 99) check("basic_pre_stop", 32'(running), 32'd1);
        end
        retire = 1'b0;
        check("basic_done", 32'(done), 32'd1);
        check("basic_not_running", 32'(running), 32'd0);
        rd(2'd0);
        check("basic_ack", 32'(rd_ack), 32'd1);
        check("basic_cycles", rd_data, 32'd101);
        rd(2'd1);
        check("basic_instr", rd_data, 32'd101);
        rd(2'd3);
        check("basic_status", rd_data, 32'b010);
        step();
        check("basic_ack_drop", 32'(rd_ack), 32'd0);
        check("basic_data_hold", rd_data, 32'b010);

        // Stall accounting: 10 stall cycles with retire low, 40 retiring, stop on the 50th.
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            stall  = (i < 10);
            retire = (i >= 10);
            pc_in  = (i == 49) ? 32'd400 : 32'd0;
            step();
        end
        stall = 1'b0; retire = 1'b0;
        check("stall_done", 32'(done), 32'd1);
        rd(2'd0);
        check("stall_cycles", rd_data, 32'd50);
        rd(2'd1);
        check("stall_instr", rd_data, 32'd40);
        rd(2'd2);
        check("stall_stalls", rd_data, EXP_STALLS);

        // Restart from DONE, then restart mid-run after 20 cycles.
        pc_in = 32'd0;
        pulse_start();
        check("rs_running", 32'(running), 32'd1);
        retire = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rd(2'd0);
        check("rs_mid_cycles", rd_data, 32'd20);
        pulse_start();
        check("rs_still_running", 32'(running), 32'd1);
        retire = 1'b0;
        for (int i = 0; i < 5; i++) step();
        pc_in = 32'd400;
        step();
        check("rs_done", 32'(done), 32'd1);
        rd(2'd0);
        check("rs_cycles", rd_data, 32'd6);
        rd(2'd1);
        check("rs_instr", rd_data, 32'd0);

        // start coinciding with the stop PC keeps the block running.
        pc_in = 32'd0;
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        pc_in = 32'd400;
        pulse_start();
        check("sw_running", 32'(running), 32'd1);
        check("sw_not_done", 32'(done), 32'd0);
        step();
        check("sw_done", 32'(done), 32'd1);
        rd(2'd0);
        check("sw_cycles", rd_data, 32'd1);

        // Pipelined reads during RUN: four back-to-back requests.
        pc_in = 32'd0;
        pulse_start();
        retire = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_req = 1'b1;
        rd_sel = 2'd0; step();
        check("pipe_ack0", 32'(rd_ack), 32'd1);
        check("pipe_cycles", rd_data, 32'd5);
        rd_sel = 2'd1; step();
        check("pipe_ack1", 32'(rd_ack), 32'd1);
        check("pipe_instr", rd_data, 32'd6);
        rd_sel = 2'd2; step();
        check("pipe_ack2", 32'(rd_ack), 32'd1);
        check("pipe_stalls", rd_data, 32'd0);
        rd_sel = 2'd3; step();
        check("pipe_ack3", 32'(rd_ack), 32'd1);
        check("pipe_status", rd_data, 32'b001);
        rd_req = 1'b0; step();
        check("pipe_ack_end", 32'(rd_ack), 32'd0);
        check("pipe_hold", rd_data, 32'b001);
        retire = 1'b0;

        // Saturation on the 4-bit instance: 20 run cycles plus the stop cycle.
        pulse_start();
        for (int i = 0; i < 20; i++) step();
        pc_in = 32'd400;
        step();
        pc_in = 32'd0;
        rd(2'd0);
        check("sat_cycles", 32'(rd_data_s), 32'd15);
        check("wide_cycles", rd_data, 32'd21);
        rd(2'd3);
        check("sat_status", 32'(rd_data_s), 32'b110);
        check("wide_status", rd_data, 32'b010);
        pulse_start();
        rd(2'd3);
        check("sat_ovf_clear", 32'(rd_data_s), 32'b001);

        // Asynchronous reset between edges with a read outstanding.
        rd_req = 1'b1; rd_sel = 2'd0;
        step();
        check("ar_ack_before", 32'(rd_ack), 32'd1);
        rd_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_done", 32'(done), 32'd0);
        check("ar_running", 32'(running), 32'd0);
        check("ar_ack", 32'(rd_ack), 32'd0);
        check("ar_data", rd_data, 32'd0);
        step();
        reset = 1'b0;
        step();
        rd(2'd0);
        check("ar_cycles", rd_data, 32'd0);
        rd(2'd3);
        check("ar_status", rd_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
